// File: rtl/bcd_display_driver_if.sv
// Handshake and result bundle between the max-search stage and the BCD display driver.
// The master supplies start/data_in; the slave returns status, BCD digits and segments.
interface bcd_display_driver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  busy;
    logic                  done;
    logic [15:0]           bcd_out;
    logic [6:0]            display_data_unidades;
    logic [6:0]            display_data_decenas;
    logic [6:0]            display_data_centenas;
    logic [6:0]            display_data_miles;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  display_data_unidades,
        input  display_data_decenas,
        input  display_data_centenas,
        input  display_data_miles
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output bcd_out,
        output display_data_unidades,
        output display_data_decenas,
        output display_data_centenas,
        output display_data_miles
    );
endinterface

// File: rtl/bcd_display_driver.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per enabled cycle)
// driving four registered active-low 7-segment displays.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last converted value
// CONVERT | one add-3 correction plus left shift per enabled edge
// DONE    | latch digits and segment encodings, pulse done, back to IDLE
module bcd_display_driver #(
    parameter int DATA_WIDTH    = 8,
    parameter bit BLANK_LEADING = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    bcd_display_driver_if.slave  bus
);

    localparam int CNT_W = 4;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                   state;
    logic [DATA_WIDTH-1:0]    shift_reg;
    logic [15:0]              acc;
    logic [CNT_W-1:0]         cnt;

    logic [15:0]              corrected;
    logic [15+DATA_WIDTH:0]   shifted;
    logic                     blank_miles;
    logic                     blank_centenas;
    logic                     blank_decenas;

    // Active-low gfedcba encoding; anything above 9 or a blanked digit is dark.
    function automatic logic [6:0] seg7(input logic [3:0] digit, input logic blank);
        logic [6:0] seg;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = SEG_BLANK;
            endcase
        end
        return seg;
    endfunction

    // Add-3 on every nibble that is 5 or more, then shift {acc, shift_reg} left by one.
    always_comb begin
        corrected = acc;
        for (int n = 0; n < 4; n++) begin
            if (acc[4*n +: 4] >= 4'd5) begin
                corrected[4*n +: 4] = acc[4*n +: 4] + 4'd3;
            end
        end
        shifted = {corrected, shift_reg} << 1;
    end

    // Leading-zero blanking cascades down from miles; unidades always shows.
    always_comb begin
        blank_miles    = BLANK_LEADING && (acc[15:12] == 4'd0);
        blank_centenas = blank_miles    && (acc[11:8] == 4'd0);
        blank_decenas  = blank_centenas && (acc[7:4]  == 4'd0);
    end

    // Conversion FSM with registered status, digits and segment outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                     <= IDLE;
            shift_reg                 <= '0;
            acc                       <= '0;
            cnt                       <= '0;
            bus.busy                  <= 1'b0;
            bus.done                  <= 1'b0;
            bus.bcd_out               <= '0;
            bus.display_data_unidades <= SEG_ZERO;
            bus.display_data_decenas  <= BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
            bus.display_data_centenas <= BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
            bus.display_data_miles    <= BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        shift_reg <= bus.data_in;
                        acc       <= '0;
                        cnt       <= CNT_W'(DATA_WIDTH);
                        bus.busy  <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc       <= shifted[15+DATA_WIDTH:DATA_WIDTH];
                    shift_reg <= shifted[DATA_WIDTH-1:0];
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.bcd_out               <= acc;
                    bus.display_data_unidades <= seg7(acc[3:0],   1'b0);
                    bus.display_data_decenas  <= seg7(acc[7:4],   blank_decenas);
                    bus.display_data_centenas <= seg7(acc[11:8],  blank_centenas);
                    bus.display_data_miles    <= seg7(acc[15:12], blank_miles);
                    bus.done                  <= 1'b1;
                    bus.busy                  <= 1'b0;
                    state                     <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
